// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined adder family.
package adder_pkg;

    localparam int DEFAULT_WIDTH   = 16;
    localparam int DEFAULT_STAGE_W = 4;

    function automatic int stage_count(input int width, input int stage_w);
        return width / stage_w;
    endfunction

endpackage

// File: rtl/pipelined_adder_slice.sv
// Combinational W-bit adder chunk with carry in and carry out.
module pipelined_adder_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined adder: WIDTH-bit add split into STAGE_W-bit chunks, one chunk per register stage.
// Define PIPELINED_ADDER_OVF_EN to add the signed-overflow output out_ovf.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int STAGE_W = DEFAULT_STAGE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    // WIDTH must be an integer multiple of STAGE_W.
    localparam int STAGES = stage_count(WIDTH, STAGE_W);

    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Each stage consumes the low chunk of the remaining operands and appends its
    // sum chunk above the completed lower chunks, so operand width shrinks as sum width grows.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IN_W   = WIDTH - k * STAGE_W;
        localparam int DONE_W = (k + 1) * STAGE_W;

        logic [IN_W-1:0]    a_src;
        logic [IN_W-1:0]    b_src;
        logic               c_src;
        logic               v_src;
        logic [STAGE_W-1:0] chunk_sum;
        logic               chunk_cout;
        logic [DONE_W-1:0]  sum_next;
        logic [DONE_W-1:0]  sum_q;
        logic               carry_q;
        logic               valid_q;
`ifdef PIPELINED_ADDER_OVF_EN
        logic               a_msb_src;
        logic               b_msb_src;
        logic               a_msb_q;
        logic               b_msb_q;
`endif

        if (k == 0) begin : g_head
            assign a_src    = in_a;
            assign b_src    = in_b;
            assign c_src    = in_cin;
            assign v_src    = in_valid && in_ready;
            assign sum_next = chunk_sum;
`ifdef PIPELINED_ADDER_OVF_EN
            assign a_msb_src = in_a[WIDTH-1];
            assign b_msb_src = in_b[WIDTH-1];
`endif
        end else begin : g_body
            assign a_src    = g_stage[k-1].g_rest.a_q;
            assign b_src    = g_stage[k-1].g_rest.b_q;
            assign c_src    = g_stage[k-1].carry_q;
            assign v_src    = g_stage[k-1].valid_q;
            assign sum_next = {chunk_sum, g_stage[k-1].sum_q};
`ifdef PIPELINED_ADDER_OVF_EN
            assign a_msb_src = g_stage[k-1].a_msb_q;
            assign b_msb_src = g_stage[k-1].b_msb_q;
`endif
        end

        pipelined_adder_slice #(
            .W (STAGE_W)
        ) u_slice (
            .a    (a_src[STAGE_W-1:0]),
            .b    (b_src[STAGE_W-1:0]),
            .cin  (c_src),
            .sum  (chunk_sum),
            .cout (chunk_cout)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
`ifdef PIPELINED_ADDER_OVF_EN
                a_msb_q <= 1'b0;
                b_msb_q <= 1'b0;
`endif
            end else if (advance) begin
                valid_q <= v_src;
                carry_q <= chunk_cout;
                sum_q   <= sum_next;
`ifdef PIPELINED_ADDER_OVF_EN
                a_msb_q <= a_msb_src;
                b_msb_q <= b_msb_src;
`endif
            end
        end

        // Operand chunks not yet added travel with the transaction.
        if (k < STAGES - 1) begin : g_rest
            logic [IN_W-STAGE_W-1:0] a_q;
            logic [IN_W-STAGE_W-1:0] b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_src[IN_W-1:STAGE_W];
                    b_q <= b_src[IN_W-1:STAGE_W];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign out_sum   = g_stage[STAGES-1].sum_q;
    assign out_cout  = g_stage[STAGES-1].carry_q;

`ifdef PIPELINED_ADDER_OVF_EN
    // Signed overflow: operands share a sign that the sum does not.
    assign out_ovf = (g_stage[STAGES-1].a_msb_q == g_stage[STAGES-1].b_msb_q) &&
                     (out_sum[WIDTH-1] != g_stage[STAGES-1].a_msb_q);
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: a 16/4 instance for directed tests and a 4/2 instance swept exhaustively.
module tb_pipelined_adder;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic        v1, r1, ov1, ordy1, cin1, co1;
    logic [15:0] a1, b1, s1;
    logic        v2, r2, ov2, ordy2, cin2, co2;
    logic [3:0]  a2, b2, s2;
`ifdef PIPELINED_ADDER_OVF_EN
    logic        ovf1, ovf2;
`endif

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t q1[$];
    exp_t q2[$];
    int   pop_cyc[$];
    exp_t m1_e;
    exp_t m2_e;

    pipelined_adder #(.WIDTH(16), .STAGE_W(4)) u_dut16 (
        .clk (clk), .rst (rst),
        .in_valid (v1), .in_ready (r1), .in_a (a1), .in_b (b1), .in_cin (cin1),
        .out_valid (ov1), .out_ready (ordy1), .out_sum (s1), .out_cout (co1)
`ifdef PIPELINED_ADDER_OVF_EN
        , .out_ovf (ovf1)
`endif
    );

    pipelined_adder #(.WIDTH(4), .STAGE_W(2)) u_dut4 (
        .clk (clk), .rst (rst),
        .in_valid (v2), .in_ready (r2), .in_a (a2), .in_b (b2), .in_cin (cin2),
        .out_valid (ov2), .out_ready (ordy2), .out_sum (s2), .out_cout (co2)
`ifdef PIPELINED_ADDER_OVF_EN
        , .out_ovf (ovf2)
`endif
    );

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors pop the scoreboard whenever a result handshake is about to complete.
    always @(negedge clk) begin
        #2;
        if (!rst && ov1 && ordy1) begin
            if (q1.size() == 0) begin
                checkOutput("dut16 spurious out_valid", ov1, 0);
            end else begin
                m1_e = q1.pop_front();
                pop_cyc.push_back(cyc);
                checkOutput("dut16 sum", s1, m1_e.sum);
                checkOutput("dut16 cout", co1, m1_e.cout);
`ifdef PIPELINED_ADDER_OVF_EN
                checkOutput("dut16 ovf", ovf1, m1_e.ovf);
`endif
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (!rst && ov2 && ordy2) begin
            if (q2.size() == 0) begin
                checkOutput("dut4 spurious out_valid", ov2, 0);
            end else begin
                m2_e = q2.pop_front();
                checkOutput("dut4 sum", s2, m2_e.sum);
                checkOutput("dut4 cout", co2, m2_e.cout);
`ifdef PIPELINED_ADDER_OVF_EN
                checkOutput("dut4 ovf", ovf2, m2_e.ovf);
`endif
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                 input logic [15:0] es, input logic ec, input logic eo);
        int tries = 0;
        @(negedge clk);
        a1 = a; b1 = b; cin1 = cin; v1 = 1'b1;
        #1;
        while (!r1 && tries < 50) begin
            @(negedge clk);
            #1;
            tries++;
        end
        if (!r1) begin
            checkOutput("dut16 in_ready timeout", r1, 1);
            v1 = 1'b0;
            return;
        end
        q1.push_back('{sum: es, cout: ec, ovf: eo});
        @(posedge clk);
        #1;
        v1 = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q1.size() != 0) checkOutput("dut16 drain timeout", q1.size(), 0);
        if (q2.size() != 0) checkOutput("dut4 drain timeout", q2.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [4:0] t;
        rst = 1'b1;
        v1 = 0; a1 = 0; b1 = 0; cin1 = 0; ordy1 = 1;
        v2 = 0; a2 = 0; b2 = 0; cin2 = 0; ordy2 = 1;
        repeat (3) @(negedge clk);
        checkOutput("reset out_valid", ov1, 0);
        checkOutput("reset out_sum", s1, 0);
        checkOutput("reset out_cout", co1, 0);
        checkOutput("dut4 reset out_valid", ov2, 0);
        rst = 1'b0;
        #1;
        checkOutput("in_ready after reset", r1, 1);
        checkOutput("dut4 in_ready after reset", r2, 1);

        // Latency: accepted at edge E0, visible after the fourth edge.
        applyStimulus(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("latency out_valid edge %0d", i + 1), ov1, (i == 3) ? 1 : 0);
        end
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        applyStimulus(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1);
        waitDrain();

        // Back-to-back: results must arrive on consecutive cycles.
        pop_cyc.delete();
        for (int i = 0; i < 8; i++)
            applyStimulus(16'(i), 16'(i), 1'b1, 16'(2 * i + 1), 1'b0, 1'b0);
        waitDrain();
        checkOutput("b2b result count", pop_cyc.size(), 8);
        if (pop_cyc.size() == 8)
            for (int k = 1; k < 8; k++)
                checkOutput($sformatf("b2b spacing %0d", k), pop_cyc[k] - pop_cyc[k-1], 1);

        // Stall with a full pipeline.
        @(negedge clk);
        ordy1 = 1'b0;
        applyStimulus(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
        applyStimulus(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        applyStimulus(16'hABCD, 16'h0F0F, 1'b1, 16'hBADD, 1'b0, 1'b0);
        applyStimulus(16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("stall in_ready %0d", i), r1, 0);
            checkOutput($sformatf("stall out_valid %0d", i), ov1, 1);
            checkOutput($sformatf("stall out_sum %0d", i), s1, 16'h2345);
        end
        @(negedge clk);
        ordy1 = 1'b1;
        waitDrain();

        // Reset with three transactions in flight.
        applyStimulus(16'h0101, 16'h0202, 1'b0, 16'h0303, 1'b0, 1'b0);
        applyStimulus(16'h1000, 16'h2000, 1'b0, 16'h3000, 1'b0, 1'b0);
        applyStimulus(16'h0F00, 16'h0100, 1'b1, 16'h1001, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        q1.delete();
        @(negedge clk);
        checkOutput("mid reset out_valid", ov1, 0);
        checkOutput("mid reset out_sum", s1, 0);
        checkOutput("mid reset out_cout", co1, 0);
        rst = 1'b0;
        #1;
        checkOutput("in_ready after mid reset", r1, 1);
        repeat (10) @(negedge clk);

        // Exhaustive sweep of the 4-bit, 2-stage instance.
        for (int n = 0; n < 512; n++) begin
            @(negedge clk);
            a2 = n[3:0]; b2 = n[7:4]; cin2 = n[8]; v2 = 1'b1;
            #1;
            if (!r2) begin
                checkOutput("dut4 in_ready sweep", r2, 1);
            end else begin
                t = 5'(n[3:0]) + 5'(n[7:4]) + 5'(n[8]);
                q2.push_back('{sum: 16'(t[3:0]), cout: t[4],
                               ovf: (n[3] == n[7]) && (t[3] != n[3])});
            end
        end
        @(negedge clk);
        v2 = 1'b0;
        waitDrain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width in bits.
REQ-002 SHALL have parameter STAGE_W, default 4, bits added per pipeline stage; WIDTH SHALL be an integer multiple of STAGE_W.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operands present.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have ports in_a, in_b  input  WIDTH  unsigned operands.
REQ-008 SHALL have port in_cin  input  1  carry-in.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out_sum  output  WIDTH  sum bits.
REQ-012 SHALL have port out_cout  output  1  carry-out of MSB.

Function
REQ-013 SHALL compute {out_cout, out_sum} = in_a + in_b + in_cin, full WIDTH+1 result, no truncation.
REQ-014 SHALL use STAGES = WIDTH/STAGE_W register stages; stage k adds chunk k (bits k*STAGE_W..), with carry registered between stages.
REQ-015 SHALL carry the not-yet-added upper operand chunks and completed lower sum chunks forward with each stage (operand skew).
REQ-016 SHALL accept a transfer when in_valid && in_ready; result appears with out_valid exactly STAGES cycles later if no stall.
REQ-017 SHALL define advance = !out_valid || out_ready; all stages shift only when advance is 1; in_ready = advance.
REQ-018 SHALL propagate bubbles: stage valid bit loads previous stage valid (stage 0 loads in_valid && in_ready).
REQ-019 SHALL hold out_sum, out_cout and all stage contents stable while out_valid && !out_ready.
REQ-020 SHALL sustain one result per cycle with out_ready held 1 and in_valid held 1.
REQ-021 SHALL deliver results strictly in acceptance order; no drop, no duplicate.
REQ-022 SHALL treat in_a/in_b/in_cin as don't-care when in_valid is 0.
REQ-023 With STAGE_W == WIDTH, SHALL degenerate to a single registered stage, latency 1.

Reset
REQ-024 On rst = 1 at a clock edge, all stage valid bits SHALL clear; out_valid = 0, out_sum = 0, out_cout = 0 the following cycle.
REQ-025 Reset mid-operation SHALL discard all in-flight transactions; none emitted afterwards.
REQ-026 in_ready SHALL be 1 in the first cycle after reset release.
REQ-027 rst SHALL take priority over any simultaneous transfer.

Configuration
REQ-028 Macro PIPELINED_ADDER_OVF_EN defined: SHALL add port out_ovf  output  1  two's-complement signed overflow (operand MSBs equal, sum MSB differs), aligned with out_sum, reset 0.
REQ-029 Macro undefined: out_ovf port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-030 Shared package adder_pkg SHALL hold default WIDTH/STAGE_W constants and a stage-count function.
REQ-031 Single sub-module pipelined_adder_slice SHALL implement the combinational STAGE_W-bit add with carry in/out; instantiated once per stage.

Verification
REQ-032 WIDTH=16, STAGE_W=4: a=0x00FF, b=0x0001, cin=0 -> 4 cycles later sum=0x0100, cout=0.
REQ-033 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1 (macro on).
REQ-034 8 back-to-back transfers (a=i, b=i, cin=1), out_ready=1 -> results 2i+1 on 8 consecutive cycles, in order.
REQ-035 Pipeline full, out_ready=0 for 3 cycles -> in_ready=0, out_sum unchanged all 3 cycles, no loss when released.
REQ-036 rst asserted with 3 transactions in flight -> out_valid=0 next cycle, no stale result ever emitted.
REQ-037 WIDTH=4, STAGE_W=2: all 512 a/b/cin combinations -> every {cout,sum} matches a+b+cin.
